console_seq: RTL
================

# console_seq

Front-panel console sequencer for the PDP-8/I on the Basys3 board. Debounces the five board buttons, arbitrates simultaneous presses, and issues fixed-width command pulses (start, stop, load_addr, dep, exam) to the pdp8i core, interlocked against the core's run state. It also time-multiplexes a selected 12-bit machine register onto the 4-digit seven-segment display in octal.

## Interface

Parameters:
- DEB_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- PULSE_CYCLES, 4: width of each command pulse, in cycles (≥1).
- SCAN_DIV, 100000: cycles per display digit (1 kHz digit rate).
- REPEAT_CYCLES, 25000000: auto-repeat interval. Used only with CONSOLE_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- btn_t, btn_b, btn_l, btn_r, btn_m  in  1 each  raw buttons: stop, start, load_addr, dep, exam.
- run  in  1  core run indicator.
- disp_sel  in  3  display source select.
- pc, ma, mb, mq, sr  in  12 each  core registers.
- lac  in  13  link + accumulator.
- dataf, instf  in  3 each  field registers.
- sc  in  5  step counter.
- start, stop, load_addr, dep, exam  out  1 each  command pulses to core.
- busy  out  1  high while the FSM is not in IDLE.
- seg7_an  out  4  anodes, active-low.
- seg7_cath  out  7  cathodes {g..a}, active-low.
- seg7_dp  out  1  decimal point, active-low.

## Operation

- Each button passes through a 2-FF synchronizer and then a per-button counter. The debounced level flips only after the synchronized input differs from it for DEB_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
- A press event is a debounced rising edge.
- FSM states: IDLE, PULSE, HOLD.
  - IDLE to PULSE: on any press event that is accepted.
  - Arbitration when several presses occur in the same cycle, highest priority first: stop > start > load_addr > dep > exam. Lower-priority presses in that cycle are discarded.
  - Interlock: start, load_addr, dep and exam are rejected while run=1, and the FSM stays in IDLE. stop is always accepted.
  - PULSE: exactly one command output is high for PULSE_CYCLES cycles, then the FSM moves to HOLD.
  - HOLD: waits until all five debounced buttons are low, then returns to IDLE. Press events seen in HOLD are ignored.
- Display:
  - The scan counter wraps at SCAN_DIV-1 and then advances the digit index 0→1→2→3→0.
  - Digit k shows value[3k+2:3k]. Digit 0 is the rightmost, on seg7_an[0].
  - Exactly one anode is low at a time.
  - disp_sel mapping: 0 pc, 1 ma, 2 mb, 3 lac[11:0], 4 mq, 5 sr, 6 {6'b0, dataf, instf}, 7 {7'b0, sc}.
  - seg7_dp is low on digit 3 only when disp_sel=3 and lac[12]=1; otherwise it is high.
  - Cathode patterns use standard 0–7 glyphs.
  - disp_sel and the register inputs are sampled combinationally each cycle. The display is not latched.

## Timing

- Reset (rst low), applied asynchronously:
  - all command pulses = 0, busy = 0
  - seg7_an = 4'b1111, seg7_cath = 7'h7F, seg7_dp = 1
  - debounced levels = 0, counters = 0, FSM = IDLE, digit index = 0
- Press latency: a raw edge held stable produces a debounced edge 2 + DEB_CYCLES cycles later. The command pulse rises on the following cycle and is registered.
- busy rises in the same cycle as the pulse and falls in the first IDLE cycle.
- run changing during PULSE or HOLD does not truncate a pulse in progress.
- A release that bounces is absorbed by the debouncer, so no second pulse is issued.
- Reset asserted mid-pulse clears the pulse immediately. After reset, buttons already held register as fresh presses once debounced.
- The first anode drives low on the cycle after the scan counter first wraps following reset.

## Configuration

- CONSOLE_AUTOREPEAT_EN defined:
  - In HOLD, when the held command is dep or exam and that button stays debounced-high, a repeat counter counts to REPEAT_CYCLES-1.
  - At that count the FSM re-enters PULSE for the same command, subject to the run interlock, and the counter clears.
  - Releasing the button clears the counter.
- Not defined: HOLD never re-pulses, and the repeat logic and REPEAT_CYCLES are unused.

## Test plan

Use DEB_CYCLES=8, PULSE_CYCLES=4, SCAN_DIV=4, REPEAT_CYCLES=20.

- btn_r held 20 cycles with run=0 → dep high for exactly 4 cycles, starting 11 cycles after the raw edge; busy high until release is debounced; no other outputs pulse.
- btn_b and btn_t rising on the same cycle → only stop pulses; start never asserts.
- run=1, press btn_l and then btn_t → load_addr never asserts; stop pulses for 4 cycles.
- btn_m toggling every 3 cycles for 30 cycles and then held → exactly one exam pulse.
- disp_sel=3, lac=13'o14321 → digits 0..3 show 1,2,3,4; dp is low on digit 3 only; each anode is low for 4 cycles in turn.
- With CONSOLE_AUTOREPEAT_EN and btn_r held 100 cycles → first dep pulse, then a repeat pulse every 24 cycles (4-cycle pulse + 20-cycle interval); without the macro → a single pulse only.

Source files
------------

// File: rtl/console_seq.sv
// rtl/console_seq.sv - PDP-8/I front-panel console sequencer and octal display scanner
//
// Debounces the five Basys3 buttons, arbitrates presses (stop > start >
// load_addr > dep > exam), issues PULSE_CYCLES-wide command pulses to the
// core (start/load_addr/dep/exam interlocked against run), and scans a
// selected 12-bit register onto the 4-digit seven-segment display in octal.
//
// Optional feature: define CONSOLE_AUTOREPEAT_EN to make a held dep/exam
// button re-issue its pulse every REPEAT_CYCLES cycles while in HOLD.
//
// Ports:
//   clk, rst (async, active-low)
//   btn_t/btn_b/btn_l/btn_r/btn_m : raw stop/start/load_addr/dep/exam buttons
//   run                           : core run indicator (interlock)
//   disp_sel                      : display source select
//   pc, ma, mb, mq, sr, lac, dataf, instf, sc : core registers for display
//   start, stop, load_addr, dep, exam : registered command pulses
//   busy                          : high while sequencer is not idle
//   seg7_an, seg7_cath, seg7_dp   : active-low display drive
module console_seq #(
    parameter int DEB_CYCLES    = 1000000,
    parameter int PULSE_CYCLES  = 4,
    parameter int SCAN_DIV      = 100000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_t,
    input  logic        btn_b,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_m,
    input  logic        run,
    input  logic [2:0]  disp_sel,
    input  logic [11:0] pc,
    input  logic [11:0] ma,
    input  logic [11:0] mb,
    input  logic [11:0] mq,
    input  logic [11:0] sr,
    input  logic [12:0] lac,
    input  logic [2:0]  dataf,
    input  logic [2:0]  instf,
    input  logic [4:0]  sc,
    output logic        start,
    output logic        stop,
    output logic        load_addr,
    output logic        dep,
    output logic        exam,
    output logic        busy,
    output logic [3:0]  seg7_an,
    output logic [6:0]  seg7_cath,
    output logic        seg7_dp
);

    // Button vector index doubles as priority: lowest index wins.
    localparam int B_STOP = 0;
    localparam int B_DEP  = 3;
    localparam int B_EXAM = 4;

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    logic [4:0]    btn_raw;
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    deb_q, deb_dly_q;
    logic [CW-1:0] cnt_q [5];
    logic [4:0]    press;
    logic [4:0]    win;
    logic          accept;

    state_t        state_q;
    logic [4:0]    cmd_q;
    logic [4:0]    pulse_q;
    logic [PW-1:0] pcnt_q;
    logic          busy_q;
    logic          rpt_fire;

    logic [SW-1:0] scnt_q;
    logic [1:0]    digit_q;
    logic          scan_on_q;
    logic [11:0]   disp_val;
    logic [2:0]    oct;
    logic [6:0]    glyph;

    assign btn_raw = {btn_m, btn_r, btn_l, btn_b, btn_t};

    // Synchronizers and per-button debounce counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    // DEB_CYCLES consecutive disagreeing cycles seen
                    cnt_q[i] <= '0;
                    deb_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press = deb_q & ~deb_dly_q;

    always_comb begin
        win = 5'b00000;
        if (press[0])      win = 5'b00001;
        else if (press[1]) win = 5'b00010;
        else if (press[2]) win = 5'b00100;
        else if (press[3]) win = 5'b01000;
        else if (press[4]) win = 5'b10000;
    end

    // Only stop may interrupt a running machine; a rejected winner also
    // discards the lower-priority presses of that cycle.
    assign accept = (|win) && (win[B_STOP] || !run);

`ifdef CONSOLE_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RW-1:0] rcnt_q;
    logic          rpt_held;

    assign rpt_held = (state_q == HOLD) &&
                      ((cmd_q[B_DEP] && deb_q[B_DEP]) || (cmd_q[B_EXAM] && deb_q[B_EXAM]));
    assign rpt_fire = rpt_held && (rcnt_q == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q <= '0;
        end else if (!rpt_held || rpt_fire) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_q + RW'(1);
        end
    end
`else
    // Auto-repeat compiled out: folds to constant 0 in every build.
    assign rpt_fire = (REPEAT_CYCLES < 0);
`endif

    // Command sequencer; pulse outputs and busy are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            pulse_q <= '0;
            pcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= PULSE;
                        cmd_q   <= win;
                        pulse_q <= win;
                        pcnt_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                PULSE: begin
                    // run is deliberately ignored here so a pulse is never cut short
                    if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
                        pulse_q <= '0;
                        state_q <= HOLD;
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                HOLD: begin
                    if (deb_q == 5'b00000) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (rpt_fire && !run) begin
                        state_q <= PULSE;
                        pulse_q <= cmd_q;
                        pcnt_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pulse_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign {exam, dep, load_addr, start, stop} = pulse_q;
    assign busy = busy_q;

    // Digit scanner; anodes stay dark until the first scan wrap after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt_q    <= '0;
            digit_q   <= 2'd0;
            scan_on_q <= 1'b0;
        end else if (scnt_q == SW'(SCAN_DIV - 1)) begin
            scnt_q <= '0;
            if (!scan_on_q) begin
                scan_on_q <= 1'b1;
            end else begin
                digit_q <= digit_q + 2'd1;
            end
        end else begin
            scnt_q <= scnt_q + SW'(1);
        end
    end

    always_comb begin
        disp_val = pc;
        case (disp_sel)
            3'd0:    disp_val = pc;
            3'd1:    disp_val = ma;
            3'd2:    disp_val = mb;
            3'd3:    disp_val = lac[11:0];
            3'd4:    disp_val = mq;
            3'd5:    disp_val = sr;
            3'd6:    disp_val = {6'b000000, dataf, instf};
            default: disp_val = {7'b0000000, sc};
        endcase
    end

    always_comb begin
        oct = disp_val[2:0];
        case (digit_q)
            2'd0:    oct = disp_val[2:0];
            2'd1:    oct = disp_val[5:3];
            2'd2:    oct = disp_val[8:6];
            default: oct = disp_val[11:9];
        endcase
    end

    // Active-low {g,f,e,d,c,b,a} glyphs for octal digits.
    always_comb begin
        glyph = 7'h7F;
        case (oct)
            3'd0:    glyph = 7'h40;
            3'd1:    glyph = 7'h79;
            3'd2:    glyph = 7'h24;
            3'd3:    glyph = 7'h30;
            3'd4:    glyph = 7'h19;
            3'd5:    glyph = 7'h12;
            3'd6:    glyph = 7'h02;
            default: glyph = 7'h78;
        endcase
    end

    always_comb begin
        seg7_an   = 4'b1111;
        seg7_cath = 7'h7F;
        seg7_dp   = 1'b1;
        if (scan_on_q) begin
            seg7_an   = ~(4'b0001 << digit_q);
            seg7_cath = glyph;
            // Link bit shown as the leftmost decimal point in LAC view.
            seg7_dp   = !((digit_q == 2'd3) && (disp_sel == 3'd3) && lac[12]);
        end
    end

endmodule
